// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 set-2 keyboard decoder.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam int unsigned KEY_W      = 11;
  localparam int unsigned PAUSE_SKIP = 7;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_REL    = 8'hF0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;
  localparam logic [7:0] PS2_BAT    = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_OVR_LO = 8'h00;
  localparam logic [7:0] PS2_OVR_HI = 8'hFF;

  // Device replies and overrun codes that never describe a key.
  function automatic logic is_reply(input logic [7:0] b);
    return (b == PS2_BAT) || (b == PS2_ACK) || (b == PS2_ECHO) ||
           (b == PS2_RESEND) || (b == PS2_OVR_LO) || (b == PS2_OVR_HI);
  endfunction

endpackage

// File: rtl/ps2_key_decoder_line_filter.sv
// Synchronizes the raw PS/2 lines, deglitches the clock and emits a falling-edge strobe.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_ps2_clk,
  input  logic i_ps2_dat,
  output logic o_fe,
  output logic o_dat
);

  localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);

  logic [1:0]       r_clk_sync;
  logic [1:0]       r_dat_sync;
  logic             r_filt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_fe;

  // Filtered level follows the synced clock only after FILTER_LEN differing cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
      r_filt     <= 1'b1;
      r_cnt      <= '0;
      r_fe       <= 1'b0;
    end else begin
      r_clk_sync <= {r_clk_sync[0], i_ps2_clk};
      r_dat_sync <= {r_dat_sync[0], i_ps2_dat};
      r_fe       <= 1'b0;
      if (r_clk_sync[1] == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(FILTER_LEN - 1)) begin
        r_cnt  <= '0;
        r_filt <= ~r_filt;
        r_fe   <= r_filt;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_fe  = r_fe;
  assign o_dat = r_dat_sync[1];

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 frame receiver and scancode decoder producing the toggle-event key word.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 49152
) (
  input  logic             I_CLK_24576M,
  input  logic             I_RESETn,
  input  logic             I_PS2_CLK,
  input  logic             I_PS2_DAT,
  output logic [KEY_W-1:0] O_KEY,
  output logic             O_ERR,
  output logic             O_BUSY
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

  logic             w_fe;
  logic             w_dat;
  ps2_state_e       r_state;
  ps2_state_e       w_state_nxt;
  logic             w_to_hit;
  logic             w_timeout;
  logic             w_frame_ok;
  logic             w_frame_bad;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic             r_par;
  logic [TO_W-1:0]  r_to_cnt;
  logic             r_byte_valid;
  logic [7:0]       r_byte;
  logic             r_ext;
  logic             r_rel;
  logic [2:0]       r_skip;
  logic [KEY_W-1:0] r_key;
  logic             r_err;
  logic             r_busy;

  ps2_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_line_filter (
    .i_clk     (I_CLK_24576M),
    .i_rst_n   (I_RESETn),
    .i_ps2_clk (I_PS2_CLK),
    .i_ps2_dat (I_PS2_DAT),
    .o_fe      (w_fe),
    .o_dat     (w_dat)
  );

  assign w_to_hit = (r_to_cnt == TO_W'(TIMEOUT_CYC));

  always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
    if (!I_RESETn) r_state <= ST_IDLE;
    else           r_state <= w_state_nxt;
  end

  // Frame sequencing; an fe strobe always takes precedence over timeout expiry.
  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    w_frame_ok  = 1'b0;
    w_frame_bad = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_fe && !w_dat) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (w_fe) begin
          if (r_bit_cnt == 3'd7) w_state_nxt = ST_PARITY;
        end else if (w_to_hit) begin
          w_state_nxt = ST_IDLE;
          w_timeout   = 1'b1;
        end
      end
      ST_PARITY: begin
        if (w_fe) begin
          w_state_nxt = ST_STOP;
        end else if (w_to_hit) begin
          w_state_nxt = ST_IDLE;
          w_timeout   = 1'b1;
        end
      end
      ST_STOP: begin
        if (w_fe) begin
          w_state_nxt = ST_IDLE;
          if ((^{r_shift, r_par}) && w_dat) w_frame_ok  = 1'b1;
          else                              w_frame_bad = 1'b1;
        end else if (w_to_hit) begin
          w_state_nxt = ST_IDLE;
          w_timeout   = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
    if (!I_RESETn) begin
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_par        <= 1'b0;
      r_to_cnt     <= '0;
      r_byte_valid <= 1'b0;
      r_byte       <= '0;
      r_err        <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_err        <= w_frame_bad | w_timeout;
      r_busy       <= (w_state_nxt != ST_IDLE);
      r_byte_valid <= w_frame_ok;
      if (w_frame_ok) r_byte <= r_shift;
      if ((r_state == ST_IDLE) || w_fe) r_to_cnt <= '0;
      else                              r_to_cnt <= r_to_cnt + TO_W'(1);
      if (w_fe) begin
        case (r_state)
          ST_IDLE:   r_bit_cnt <= '0;
          ST_DATA: begin
            r_shift   <= {w_dat, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
          ST_PARITY: r_par <= w_dat;
          default:   ;
        endcase
      end
    end
  end

  // Prefix tracking and key-word generation on each validated byte.
  always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
    if (!I_RESETn) begin
      r_ext  <= 1'b0;
      r_rel  <= 1'b0;
      r_skip <= '0;
      r_key  <= '0;
    end else if (w_frame_bad) begin
      r_ext  <= 1'b0;
      r_rel  <= 1'b0;
      r_skip <= '0;
    end else if (r_byte_valid) begin
      if (r_skip != 3'd0) begin
        r_skip <= r_skip - 3'd1;
      end else if (r_byte == PS2_PAUSE) begin
        r_skip <= 3'(PAUSE_SKIP);
        r_ext  <= 1'b0;
        r_rel  <= 1'b0;
      end else if (r_byte == PS2_EXT) begin
        r_ext <= 1'b1;
      end else if (r_byte == PS2_REL) begin
        r_rel <= 1'b1;
      end else if (!(is_reply(r_byte) && !r_ext && !r_rel)) begin
        r_key <= {~r_key[KEY_W-1], ~r_rel, r_ext, r_byte};
        r_ext <= 1'b0;
        r_rel <= 1'b0;
      end
    end
  end

  assign O_KEY  = r_key;
  assign O_ERR  = r_err;
  assign O_BUSY = r_busy;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench: directed frame table, multi-cycle corner sequences, randomized frames vs. a byte-level model.
module tb_ps2_key_decoder;

  localparam int unsigned TO = 2000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ps2_clk;
  logic        ps2_dat;
  logic [10:0] key;
  logic        err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  int ev_cnt = 0;
  int err_cnt = 0;
  int err_long = 0;
  logic prev_tog = 1'b0;
  logic prev_err = 1'b0;

  logic [10:0] m_key;
  bit          m_ext, m_rel;
  int          m_skip;
  bit          exp_tog;

  typedef struct {
    logic [7:0] b;
    bit         bad;
    bit         ev;
    logic [9:0] low;
    bit         er;
  } vec_t;
  vec_t vecs[10];

  always #20 clk = ~clk;

  ps2_key_decoder #(
    .FILTER_LEN  (8),
    .TIMEOUT_CYC (TO)
  ) dut (
    .I_CLK_24576M (clk),
    .I_RESETn     (rst_n),
    .I_PS2_CLK    (ps2_clk),
    .I_PS2_DAT    (ps2_dat),
    .O_KEY        (key),
    .O_ERR        (err),
    .O_BUSY       (busy)
  );

  // Counts events (bit-10 changes) and error pulses, and flags error pulses longer than one cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_tog = 1'b0;
      prev_err = 1'b0;
    end else begin
      if (key[10] !== prev_tog) ev_cnt++;
      prev_tog = key[10];
      if (err === 1'b1) begin
        err_cnt++;
        if (prev_err) err_long++;
      end
      prev_err = err;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input int half, input bit glitch);
    ps2_dat = b;
    wait_cyc(half);
    ps2_clk = 1'b0;
    wait_cyc(half);
    ps2_clk = 1'b1;
    if (glitch) begin
      wait_cyc(15);
      ps2_clk = 1'b0;
      wait_cyc(5);
      ps2_clk = 1'b1;
      wait_cyc(8);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int half, input bit glitch);
    logic par;
    par = ~(^b) ^ bad_par;
    send_bit(1'b0, half, glitch);
    for (int i = 0; i < 8; i++) send_bit(b[i], half, glitch);
    send_bit(par, half, glitch);
    send_bit(~bad_stop, half, glitch);
    ps2_dat = 1'b1;
    wait_cyc(30);
  endtask

  // Byte-level reference: applies the prefix/skip/ignore rules to one received byte.
  task automatic model_byte(input logic [7:0] b, input bit bad, output bit ev);
    ev = 1'b0;
    if (bad) begin
      m_ext = 0; m_rel = 0; m_skip = 0;
    end else if (m_skip > 0) begin
      m_skip--;
    end else if (b == 8'hE1) begin
      m_skip = 7; m_ext = 0; m_rel = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_rel = 1;
    end else if ((b == 8'hAA || b == 8'hFA || b == 8'hEE || b == 8'hFE ||
                  b == 8'h00 || b == 8'hFF) && !m_ext && !m_rel) begin
      ev = 1'b0;
    end else begin
      m_key = {~m_key[10], ~m_rel, m_ext, b};
      m_ext = 0; m_rel = 0;
      ev = 1'b1;
    end
  endtask

  task automatic model_reset();
    m_key = '0; m_ext = 0; m_rel = 0; m_skip = 0; exp_tog = 0;
  endtask

  initial begin
    #(40 * 99000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, r0, half;
    bit ev, bad, bad_stop;
    logic [7:0] b;
    logic [7:0] pause_seq[9];
    logic [7:0] replies[6];

    vecs[0] = '{8'h1C, 1'b0, 1'b1, 10'h21C, 1'b0};
    vecs[1] = '{8'hF0, 1'b0, 1'b0, 10'h21C, 1'b0};
    vecs[2] = '{8'h1C, 1'b0, 1'b1, 10'h01C, 1'b0};
    vecs[3] = '{8'hE0, 1'b0, 1'b0, 10'h01C, 1'b0};
    vecs[4] = '{8'h75, 1'b0, 1'b1, 10'h375, 1'b0};
    vecs[5] = '{8'hE0, 1'b0, 1'b0, 10'h375, 1'b0};
    vecs[6] = '{8'hF0, 1'b0, 1'b0, 10'h375, 1'b0};
    vecs[7] = '{8'h75, 1'b0, 1'b1, 10'h175, 1'b0};
    vecs[8] = '{8'h1C, 1'b1, 1'b0, 10'h175, 1'b1};
    vecs[9] = '{8'h29, 1'b0, 1'b1, 10'h229, 1'b0};
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h5A};
    replies   = '{8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

    rst_n = 1'b0; ps2_clk = 1'b1; ps2_dat = 1'b1;
    model_reset();
    wait_cyc(5);
    check("reset_key", 32'(key), 32'h0);
    check("reset_err", 32'(err), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    wait_cyc(20);

    // Directed table; the first frame uses a 60 us bit period.
    for (int i = 0; i < 10; i++) begin
      e0 = ev_cnt; r0 = err_cnt;
      half = (i == 0) ? 750 : 25;
      send_frame(vecs[i].b, vecs[i].bad, 1'b0, half, 1'b0);
      model_byte(vecs[i].b, vecs[i].bad, ev);
      if (vecs[i].ev) exp_tog = ~exp_tog;
      check($sformatf("tbl%0d_low", i), 32'(key[9:0]), 32'(vecs[i].low));
      check($sformatf("tbl%0d_tog", i), 32'(key[10]), 32'(exp_tog));
      check($sformatf("tbl%0d_events", i), 32'(ev_cnt - e0), 32'(vecs[i].ev));
      check($sformatf("tbl%0d_errs", i), 32'(err_cnt - r0), 32'(vecs[i].er));
    end

    // Frame stalls after 5 data bits long enough to time out.
    e0 = ev_cnt; r0 = err_cnt;
    send_bit(1'b0, 25, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'(i & 1), 25, 1'b0);
    wait_cyc(5);
    check("to_busy_mid", 32'(busy), 32'h1);
    wait_cyc(3 * TO);
    check("to_err", 32'(err_cnt - r0), 32'h1);
    check("to_busy_after", 32'(busy), 32'h0);
    check("to_no_event", 32'(ev_cnt - e0), 32'h0);
    send_frame(8'h6B, 1'b0, 1'b0, 25, 1'b0);
    model_byte(8'h6B, 1'b0, ev);
    check("to_next_low", 32'(key[9:0]), 32'h26B);
    check("to_next_model", 32'(key), 32'(m_key));

    // Clock glitches between bits plus a pause sequence then 5A.
    e0 = ev_cnt; r0 = err_cnt;
    for (int i = 0; i < 9; i++) begin
      send_frame(pause_seq[i], 1'b0, 1'b0, 30, 1'b1);
      model_byte(pause_seq[i], 1'b0, ev);
    end
    check("pause_events", 32'(ev_cnt - e0), 32'h1);
    check("pause_low", 32'(key[9:0]), 32'h25A);
    check("pause_errs", 32'(err_cnt - r0), 32'h0);
    check("pause_model", 32'(key), 32'(m_key));

    // Reset in the middle of a frame.
    send_bit(1'b0, 25, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 25, 1'b0);
    check("rst_busy_pre", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_key", 32'(key), 32'h0);
    check("rst_mid_busy", 32'(busy), 32'h0);
    ps2_clk = 1'b1; ps2_dat = 1'b1;
    wait_cyc(5);
    rst_n = 1'b1;
    model_reset();
    wait_cyc(20);

    // Randomized frames against the byte-level model.
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 15))
        0, 1:    b = 8'hE0;
        2, 3:    b = 8'hF0;
        4:       b = 8'hE1;
        5, 6:    b = replies[$urandom_range(0, 5)];
        default: b = 8'($urandom);
      endcase
      bad      = ($urandom_range(0, 7) == 0);
      bad_stop = bad && ($urandom_range(0, 1) == 1);
      half     = int'($urandom_range(15, 30));
      e0 = ev_cnt; r0 = err_cnt;
      send_frame(b, bad && !bad_stop, bad_stop, half, 1'b0);
      model_byte(b, bad, ev);
      check($sformatf("rnd%0d_key", n), 32'(key), 32'(m_key));
      check($sformatf("rnd%0d_events", n), 32'(ev_cnt - e0), 32'(ev));
      check($sformatf("rnd%0d_errs", n), 32'(err_cnt - r0), 32'(bad));
    end

    check("err_pulse_width", 32'(err_long), 32'h0);
    check("idle_busy", 32'(busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
